// File: rtl/bs_pkg.sv
// Shared definitions for the serialized barrel shifter scheduler.
// Holds the data width, the shift op encodings and the sequencing FSM states.
package bs_pkg;
    localparam int W = 8;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_LSL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ST1  = 3'd1,
        ST2  = 3'd2,
        ST4  = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/bs_stage.sv
// One conditional shift stage of fixed distance SH.
// When en is low the data passes through unchanged.
module bs_stage
    import bs_pkg::*;
#(
    parameter int SH = 1
) (
    input  logic [W-1:0] data,
    input  logic [1:0]   op,
    input  logic         en,
    input  logic         sign,
    output logic [W-1:0] shifted
);
    always_comb begin
        shifted = data;
        if (en) begin
            case (op)
                OP_LSR:  shifted = data >> SH;
                OP_LSL:  shifted = data << SH;
                OP_ROR:  shifted = (data >> SH) | (data << (W - SH));
                default: shifted = (data >> SH) | ({W{sign}} << (W - SH));
            endcase
        end
    end
endmodule

// File: rtl/barrel_shift_sched.sv
// Round-robin front end for a shared 8-bit shifter applied as 1/2/4 stages
// over three cycles; the result is held until the consumer takes it.
module barrel_shift_sched
    import bs_pkg::*;
#(
    parameter int   W       = 8,
    parameter logic RR_INIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_data,
    input  logic [2:0]   req0_amt,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_data,
    input  logic [2:0]   req1_amt,
    input  logic [1:0]   req1_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_id
);
    state_t       state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [2:0]   amt_q, amt_d;
    logic [1:0]   op_q, op_d;
    logic         id_q, id_d;
    logic         last_grant_q, last_grant_d;

    logic         grant_id;
    logic         accept;
    logic [W-1:0] s1_data, s2_data, s4_data;

    // Each stage sees the working register; sign is stable because ASR keeps bit 7.
    bs_stage #(.SH(1)) u_st1 (.data(data_q), .op(op_q), .en(amt_q[0]), .sign(data_q[W-1]), .shifted(s1_data));
    bs_stage #(.SH(2)) u_st2 (.data(data_q), .op(op_q), .en(amt_q[1]), .sign(data_q[W-1]), .shifted(s2_data));
    bs_stage #(.SH(4)) u_st4 (.data(data_q), .op(op_q), .en(amt_q[2]), .sign(data_q[W-1]), .shifted(s4_data));

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        amt_d        = amt_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        if (req0_valid && !req1_valid) begin
            grant_id = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_id = 1'b1;
        end else begin
            grant_id = !last_grant_q;
        end
        accept = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req0_ready   = !grant_id;
                    req1_ready   = grant_id;
                    data_d       = grant_id ? req1_data : req0_data;
                    amt_d        = grant_id ? req1_amt  : req0_amt;
                    op_d         = grant_id ? req1_op   : req0_op;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ST1;
                end
            end
            ST1: begin
                data_d  = s1_data;
                state_d = ST2;
            end
            ST2: begin
                data_d  = s2_data;
                state_d = ST4;
            end
            ST4: begin
                data_d  = s4_data;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            amt_q        <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= RR_INIT;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            amt_q        <= amt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_id    = id_q;
endmodule

// File: tb/tb_barrel_shift_sched.sv
// Scoreboard bench for barrel_shift_sched: acceptances push hand-computed
// results, a monitor pops and compares on each output handshake.
module tb_barrel_shift_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [2:0] req0_amt, req1_amt;
    logic [1:0] req0_op, req1_op;
    logic       out_valid, out_ready, out_id;
    logic [7:0] out_data;

    typedef struct {
        logic [7:0] data;
        logic       id;
        int         acc;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         glog_id[$];
    int         glog_cyc[$];
    logic [7:0] exp0, exp1;
    bit         seen;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    barrel_shift_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance watcher: pushes the expected result for whichever requester is taken.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (req0_ready && req1_ready) chk("dual_ready", 1, 0);
            if (req0_valid && req0_ready) begin
                sbq.push_back('{data: exp0, id: 1'b0, acc: cyc});
                glog_id.push_back(0);
                glog_cyc.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                sbq.push_back('{data: exp1, id: 1'b1, acc: cyc});
                glog_id.push_back(1);
                glog_cyc.push_back(cyc);
            end
        end
    end

    // Output monitor.
    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", cyc - sbq[0].acc, 4);
                end
                if (out_ready) begin
                    mon_e = sbq.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("out_id", out_id, mon_e.id);
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    task automatic issue(input bit id, input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] o, input logic [7:0] e);
        int n = 0;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_op = o; exp1 = e;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_op = o; exp0 = e;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", n < 40, 1);
        @(negedge clk);
        // Scramble the payload after acceptance; it must have been latched.
        if (id) begin
            req1_valid = 1'b0; req1_data = ~d; req1_amt = ~a; req1_op = ~o;
        end else begin
            req0_valid = 1'b0; req0_data = ~d; req0_amt = ~a; req0_op = ~o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; out_ready = 1'b1; seen = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_op = '0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_op = '0;
        exp0 = '0; exp1 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_id", out_id, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        issue(0, 8'b1011_0110, 3'd3, 2'b00, 8'b0001_0110); wait_drain();
        issue(1, 8'h96, 3'd5, 2'b11, 8'hFC);               wait_drain();

        // Contention: last grant was requester 1, so requester 0 leads.
        glog_id.delete(); glog_cyc.delete();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd1; req0_op = 2'b01; exp0 = 8'h02;
        req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 3'd1; req1_op = 2'b10; exp1 = 8'hC0;
        n = 0;
        while (glog_id.size() < 4 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();
        chk("rr_count", glog_id.size(), 4);
        if (glog_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", glog_id[i], i % 2);
            for (int i = 1; i < 4; i++) chk("rr_spacing", glog_cyc[i] - glog_cyc[i-1], 5);
        end

        issue(0, 8'h96, 3'd3, 2'b10, 8'hD2); wait_drain();
        issue(1, 8'h96, 3'd7, 2'b01, 8'h00); wait_drain();
        for (int i = 0; i < 4; i++) begin
            issue(i[0], 8'h5A, 3'd0, i[1:0], 8'h5A);
            wait_drain();
        end
        issue(1, 8'h01, 3'd7, 2'b10, 8'h02); wait_drain();
        issue(0, 8'h80, 3'd7, 2'b11, 8'hFF); wait_drain();

        // Backpressure with requester 1 waiting.
        out_ready = 1'b0;
        issue(0, 8'h40, 3'd6, 2'b11, 8'h01);
        req1_valid = 1'b1; req1_data = 8'h01; req1_amt = 3'd7; req1_op = 2'b10; exp1 = 8'h02;
        n = 0;
        #1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (6) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h01);
            chk("bp_id", out_id, 0);
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_regrant", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_drain();

        // Reset while the operation sits in ST2.
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'hF0; req0_amt = 3'd4; req0_op = 2'b00; exp0 = 8'h0F;
        n = 0;
        #1;
        while (!req0_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h96; req1_amt = 3'd1; req1_op = 2'b00; exp1 = 8'h4B;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 8'h00);
        chk("mid_rst_req0_ready", req0_ready, 0);
        sbq.delete();
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        glog_id.delete(); glog_cyc.delete();
        #1;
        chk("post_rst_req0_ready", req0_ready, 1);
        chk("post_rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();
        chk("post_rst_grants", glog_id.size(), 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
